// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode constants, controller state type and CPOL/CPHA decode helpers
package spi_pkg;
    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;
    typedef enum logic {IDLE, BUSY} spi_state_e;
    function automatic logic cpol(input int mode);
        return (mode == SPI_MODE2) || (mode == SPI_MODE3);
    endfunction
    function automatic logic cpha(input int mode);
        return (mode == SPI_MODE1) || (mode == SPI_MODE3);
    endfunction
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: byte handshake plus serial pins of the SPI master
interface spi_master_if;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_SPI_Clk;
    logic       i_SPI_MISO;
    logic       o_SPI_MOSI;
    modport master (
        input  i_TX_Byte, i_TX_DV, i_SPI_MISO,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI
    );
    modport slave (
        output i_TX_Byte, i_TX_DV, i_SPI_MISO,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_SPI_Clk, o_SPI_MOSI
    );
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCK divider producing 16 edges per byte with registered leading/trailing strobes
module spi_clk_gen #(
    parameter int   CLKS_PER_HALF_BIT = 2,
    parameter logic CPOL              = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic sck,
    output logic lead,
    output logic trail,
    output logic busy
);
    localparam int CW = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [CW-1:0] LEAD_AT  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] TRAIL_AT = CW'(2 * CLKS_PER_HALF_BIT - 1);
    logic [CW-1:0] half_q, half_d;
    logic [4:0]    edges_q, edges_d;
    logic          sck_q, sck_d, lead_q, lead_d, trail_q, trail_d;
    always_comb begin
        half_d  = half_q;
        edges_d = edges_q;
        sck_d   = sck_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        if (start) begin
            edges_d = 5'd16;
            half_d  = '0;
            sck_d   = CPOL;
        end else if (edges_q != 5'd0) begin
            lead_d  = half_q == LEAD_AT;
            trail_d = half_q == TRAIL_AT;
            half_d  = trail_d ? '0 : half_q + 1'b1;
            if (lead_d || trail_d) begin
                sck_d   = ~sck_q;
                edges_d = edges_q - 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            half_q  <= '0;
            edges_q <= '0;
            sck_q   <= CPOL;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            edges_q <= edges_d;
            sck_q   <= sck_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
        end
    end
    assign sck   = sck_q;
    assign lead  = lead_q;
    assign trail = trail_q;
    assign busy  = edges_q != 5'd0;
endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI master shifting MOSI out and capturing MISO, MSB first
module spi_master import spi_pkg::*; #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input logic          i_Clk,
    input logic          i_Rst,
    spi_master_if.master bus
);
    localparam logic CPOL = cpol(SPI_MODE);
    localparam logic CPHA = cpha(SPI_MODE);
    spi_state_e state_q, state_d;
    logic       accept, sck_int, lead, trail, busy;
    logic [7:0] tx_byte_q, tx_byte_d, rx_byte_q, rx_byte_d;
    logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic       tx_dv_q, tx_dv_d, mosi_q, mosi_d, rx_dv_q, rx_dv_d, spi_clk_q, spi_clk_d;
    spi_clk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT), .CPOL(CPOL)) u_clk_gen (
        .clk(i_Clk), .rst(i_Rst), .start(accept),
        .sck(sck_int), .lead(lead), .trail(trail), .busy(busy)
    );
    always_comb begin
        accept    = (state_q == IDLE) && bus.i_TX_DV;
        state_d   = (state_q == IDLE) ? (bus.i_TX_DV ? BUSY : IDLE) : (busy ? BUSY : IDLE);
        tx_byte_d = accept ? bus.i_TX_Byte : tx_byte_q;
        tx_dv_d   = accept;
        spi_clk_d = sck_int;
        tx_bit_d  = tx_bit_q;
        mosi_d    = mosi_q;
        rx_byte_d = rx_byte_q;
        rx_bit_d  = rx_bit_q;
        rx_dv_d   = 1'b0;
        // CPHA=0 presents bit 7 before the first leading edge, so the first trailing edge sends bit 6
        if (state_q == IDLE) begin
            tx_bit_d = 3'd7;
        end else if (tx_dv_q && !CPHA) begin
            mosi_d   = tx_byte_q[7];
            tx_bit_d = 3'd6;
        end else if (CPHA ? lead : trail) begin
            mosi_d   = tx_byte_q[tx_bit_q];
            tx_bit_d = tx_bit_q - 1'b1;
        end
        if (state_q == IDLE) begin
            rx_bit_d = 3'd7;
        end else if (CPHA ? trail : lead) begin
            rx_byte_d[rx_bit_q] = bus.i_SPI_MISO;
            rx_bit_d            = rx_bit_q - 1'b1;
            rx_dv_d             = rx_bit_q == 3'd0;
        end
    end
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= BUSY;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            tx_bit_q  <= 3'd7;
            mosi_q    <= 1'b0;
            rx_byte_q <= '0;
            rx_bit_q  <= 3'd7;
            rx_dv_q   <= 1'b0;
            spi_clk_q <= CPOL;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            tx_bit_q  <= tx_bit_d;
            mosi_q    <= mosi_d;
            rx_byte_q <= rx_byte_d;
            rx_bit_q  <= rx_bit_d;
            rx_dv_q   <= rx_dv_d;
            spi_clk_q <= spi_clk_d;
        end
    end
    assign bus.o_TX_Ready = state_q == IDLE;
    assign bus.o_RX_DV    = rx_dv_q;
    assign bus.o_RX_Byte  = rx_byte_q;
    assign bus.o_SPI_Clk  = spi_clk_q;
    assign bus.o_SPI_MOSI = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master in modes 0, 3 and 1
module tb_spi_master;
    import spi_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    spi_master_if a_if ();
    spi_master_if b_if ();
    spi_master_if c_if ();
    spi_master #(.SPI_MODE(SPI_MODE0), .CLKS_PER_HALF_BIT(3)) dut_a (.i_Clk(clk), .i_Rst(rst), .bus(a_if));
    spi_master #(.SPI_MODE(SPI_MODE3), .CLKS_PER_HALF_BIT(3)) dut_b (.i_Clk(clk), .i_Rst(rst), .bus(b_if));
    spi_master #(.SPI_MODE(SPI_MODE1), .CLKS_PER_HALF_BIT(2)) dut_c (.i_Clk(clk), .i_Rst(rst), .bus(c_if));
    assign a_if.i_SPI_MISO = a_if.o_SPI_MOSI;
    assign c_if.i_SPI_MISO = c_if.o_SPI_MOSI;
    int tests = 0, fails = 0, cyc = 0;
    int rise_a = 0, rise_b = 0, rise_c = 0, low_a = 0, low_b = 0, low_c = 0;
    int dv_a = 0, dv_b = 0, dv_c = 0, bad_b = 0, prev_rt_c = 0, last_rt_c = 0;
    logic [15:0] mosi_a = '0;
    logic [7:0]  mosi_b = '0, rx_last_a = '0, rx_prev_a = '0, rx_last_b = '0, rx_last_c = '0;
    logic        pm_b = 1'b0, ps_b = 1'b1, b_go = 1'b0;
    logic [7:0]  slv = 8'hC3;
    int          slave_bit = 7;
    // Mode 3 slave: presents the next bit of slv on each falling SCK edge
    always @(negedge b_if.o_SPI_Clk) begin
        if (b_go && slave_bit >= 0) begin
            b_if.i_SPI_MISO = slv[slave_bit[2:0]];
            slave_bit--;
        end
    end
    always @(posedge a_if.o_SPI_Clk) begin
        rise_a++;
        mosi_a = {mosi_a[14:0], a_if.o_SPI_MOSI};
    end
    always @(posedge b_if.o_SPI_Clk) begin
        rise_b++;
        mosi_b = {mosi_b[6:0], b_if.o_SPI_MOSI};
    end
    always @(posedge c_if.o_SPI_Clk) begin
        rise_c++;
        prev_rt_c = last_rt_c;
        last_rt_c = cyc;
    end
    always @(negedge clk) begin
        cyc++;
        if (!a_if.o_TX_Ready) low_a++;
        if (!b_if.o_TX_Ready) low_b++;
        if (!c_if.o_TX_Ready) low_c++;
        if (a_if.o_RX_DV) begin dv_a++; rx_prev_a = rx_last_a; rx_last_a = a_if.o_RX_Byte; end
        if (b_if.o_RX_DV) begin dv_b++; rx_last_b = b_if.o_RX_Byte; end
        if (c_if.o_RX_DV) begin dv_c++; rx_last_c = c_if.o_RX_Byte; end
        if (b_if.o_SPI_MOSI !== pm_b && !(ps_b === 1'b1 && b_if.o_SPI_Clk === 1'b0)) bad_b++;
        pm_b = b_if.o_SPI_MOSI;
        ps_b = b_if.o_SPI_Clk;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input int w, input logic [7:0] d, input logic v);
        if (w == 0) begin a_if.i_TX_Byte = d; a_if.i_TX_DV = v; end
        else if (w == 1) begin b_if.i_TX_Byte = d; b_if.i_TX_DV = v; end
        else begin c_if.i_TX_Byte = d; c_if.i_TX_DV = v; end
    endtask
    function automatic logic rdy(input int w);
        return (w == 0) ? a_if.o_TX_Ready : (w == 1) ? b_if.o_TX_Ready : c_if.o_TX_Ready;
    endfunction
    task automatic pulse(input int w, input logic [7:0] d);
        drive(w, d, 1'b1);
        @(negedge clk);
        drive(w, d, 1'b0);
    endtask
    task automatic wait_ready(input int w, input string tag);
        int n = 0;
        while (rdy(w) !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 300), 32'd1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int br, bl, bd, bb;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ready", a_if.o_TX_Ready, 0);
        chk("rst_rx_dv", a_if.o_RX_DV, 0);
        chk("rst_rx_byte", a_if.o_RX_Byte, 0);
        chk("rst_mosi", a_if.o_SPI_MOSI, 0);
        chk("rst_sck_mode0", a_if.o_SPI_Clk, 0);
        chk("rst_sck_mode3", b_if.o_SPI_Clk, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", a_if.o_TX_Ready, 1);
        br = rise_a; bl = low_a; bd = dv_a;
        pulse(0, 8'hAB);
        wait_ready(0, "m0_ab");
        @(negedge clk);
        chk("m0_ab_mosi", mosi_a[7:0], 8'hAB);
        chk("m0_ab_rises", rise_a - br, 8);
        chk("m0_ab_rx", rx_last_a, 8'hAB);
        chk("m0_ab_rx_hold", a_if.o_RX_Byte, 8'hAB);
        chk("m0_ab_dv_count", dv_a - bd, 1);
        chk("m0_ab_ready_low", low_a - bl, 49);
        chk("m0_ab_sck_idle", a_if.o_SPI_Clk, 0);
        br = rise_a; bl = low_a; bd = dv_a;
        pulse(0, 8'h11);
        repeat (9) @(negedge clk);
        pulse(0, 8'hFF);
        wait_ready(0, "busy_dv");
        @(negedge clk);
        chk("busy_dv_mosi", mosi_a[7:0], 8'h11);
        chk("busy_dv_rx", rx_last_a, 8'h11);
        chk("busy_dv_count", dv_a - bd, 1);
        chk("busy_dv_ready_low", low_a - bl, 49);
        br = rise_a; bl = low_a; bd = dv_a;
        pulse(0, 8'h00);
        wait_ready(0, "b2b_first");
        pulse(0, 8'hFF);
        wait_ready(0, "b2b_second");
        @(negedge clk);
        chk("b2b_mosi", mosi_a, 16'h00FF);
        chk("b2b_rises", rise_a - br, 16);
        chk("b2b_dv_count", dv_a - bd, 2);
        chk("b2b_rx_first", rx_prev_a, 8'h00);
        chk("b2b_rx_second", rx_last_a, 8'hFF);
        chk("b2b_ready_low", low_a - bl, 98);
        bd = dv_a;
        pulse(0, 8'h3C);
        repeat (22) @(negedge clk);
        chk("mid_sck_high", a_if.o_SPI_Clk, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sck", a_if.o_SPI_Clk, 0);
        chk("mid_rst_rx_dv", a_if.o_RX_DV, 0);
        chk("mid_rst_ready", a_if.o_TX_Ready, 0);
        chk("mid_rst_rx_byte", a_if.o_RX_Byte, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_release_ready", a_if.o_TX_Ready, 1);
        repeat (60) @(negedge clk);
        chk("mid_no_rx_dv", dv_a - bd, 0);
        chk("m3_sck_idle", b_if.o_SPI_Clk, 1);
        br = rise_b; bl = low_b; bd = dv_b; bb = bad_b;
        b_go = 1'b1;
        pulse(1, 8'h5A);
        wait_ready(1, "m3");
        @(negedge clk);
        chk("m3_rx", rx_last_b, 8'hC3);
        chk("m3_mosi", mosi_b, 8'h5A);
        chk("m3_rises", rise_b - br, 8);
        chk("m3_mosi_on_fall", bad_b - bb, 0);
        chk("m3_dv_count", dv_b - bd, 1);
        chk("m3_ready_low", low_b - bl, 49);
        chk("m3_sck_idle_after", b_if.o_SPI_Clk, 1);
        br = rise_c; bl = low_c; bd = dv_c;
        pulse(2, 8'h96);
        wait_ready(2, "m1");
        @(negedge clk);
        chk("m1_rx", rx_last_c, 8'h96);
        chk("m1_rises", rise_c - br, 8);
        chk("m1_sck_period", last_rt_c - prev_rt_c, 4);
        chk("m1_ready_low", low_c - bl, 33);
        chk("m1_dv_count", dv_c - bd, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
